mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter: three-requester arbiter in front of a single-port RAM.  |
// | Optional round-robin priority when ARB_ROUND_ROBIN_EN is defined.         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int RAM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [2:0]  if_addr,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic        out_req,
  input  logic [2:0]  out_addr,
  output logic        if_gnt,
  output logic        mem_gnt,
  output logic        out_gnt,
  output logic        if_valid,
  output logic        mem_valid,
  output logic        out_valid,
  output logic [15:0] rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [2:0]  ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] LAST_WAIT = 2'(RAM_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  win_q, win_d;      // one-hot winner: bit0 mem, bit1 if, bit2 out
  logic [2:0]  addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;

  logic [2:0]  req_vec;
  logic [2:0]  pick_vec;
  logic [1:0]  first_idx;

  // Scan from lowest to highest priority so the highest requester overwrites.
  function automatic logic [2:0] pick(input logic [2:0] req, input logic [1:0] first);
    logic [2:0] g;
    logic [2:0] s;
    g = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      s = {1'b0, first} + 3'(i);
      if (s > 3'd2) s = s - 3'd3;
      if (req[s[1:0]]) g = 3'b001 << s[1:0];
    end
    return g;
  endfunction

  assign req_vec  = {out_req, if_req, mem_req};
  assign pick_vec = pick(req_vec, first_idx);

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  assign first_idx = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && |req_vec) begin
      ptr_d = pick_vec[0] ? 2'd1 : (pick_vec[1] ? 2'd2 : 2'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 2'd0;
    else        ptr_q <= ptr_d;
  end
`else
  assign first_idx = 2'd0;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          win_d   = pick_vec;
          we_d    = pick_vec[0] & mem_we;
          wdata_d = mem_wdata;
          addr_d  = pick_vec[0] ? mem_addr : (pick_vec[1] ? if_addr : out_addr);
          cnt_d   = 2'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          if (!we_q) rdata_d = ram_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= 3'b000;
      addr_q  <= 3'd0;
      we_q    <= 1'b0;
      wdata_q <= 16'd0;
      cnt_q   <= 2'd0;
      rdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode straight from state so reset clears them without a clock.
  assign busy   = (state_q != IDLE);
  assign ram_en = (state_q == WAIT) && (cnt_q == 2'd0);
  assign ram_we = ram_en & we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign {out_gnt, if_gnt, mem_gnt}       = win_q & {3{state_q != IDLE}};
  assign {out_valid, if_valid, mem_valid} = win_q & {3{state_q == RESP}};

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (RAM_LAT 1/2/3)|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam logic [1:0] ID_MEM = 2'd0;
  localparam logic [1:0] ID_IF  = 2'd1;
  localparam logic [1:0] ID_OUT = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_aux_n;
  logic        if_req, mem_req, mem_we, out_req;
  logic [2:0]  if_addr, mem_addr, out_addr;
  logic [15:0] mem_wdata;
  logic        if_gnt, mem_gnt, out_gnt, if_valid, mem_valid, out_valid;
  logic [15:0] rdata, ram_wdata, ram_rdata;
  logic        ram_en, ram_we, busy;
  logic [2:0]  ram_addr;

  mem_port_arbiter #(.RAM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .out_req(out_req), .out_addr(out_addr),
    .if_gnt(if_gnt), .mem_gnt(mem_gnt), .out_gnt(out_gnt),
    .if_valid(if_valid), .mem_valid(mem_valid), .out_valid(out_valid),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  // Latency-1 and latency-3 instances, fed a continuously held fetch request.
  logic        l1_if_gnt, l1_mem_gnt, l1_out_gnt, l1_if_valid, l1_mem_valid, l1_out_valid;
  logic        l1_ram_en, l1_ram_we, l1_busy;
  logic [2:0]  l1_ram_addr;
  logic [15:0] l1_rdata, l1_ram_wdata;
  logic        l3_if_gnt, l3_mem_gnt, l3_out_gnt, l3_if_valid, l3_mem_valid, l3_out_valid;
  logic        l3_ram_en, l3_ram_we, l3_busy;
  logic [2:0]  l3_ram_addr;
  logic [15:0] l3_rdata, l3_ram_wdata;

  mem_port_arbiter #(.RAM_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_aux_n),
    .if_req(1'b1), .if_addr(3'd1),
    .mem_req(1'b0), .mem_we(1'b0), .mem_addr(3'd0), .mem_wdata(16'd0),
    .out_req(1'b0), .out_addr(3'd0),
    .if_gnt(l1_if_gnt), .mem_gnt(l1_mem_gnt), .out_gnt(l1_out_gnt),
    .if_valid(l1_if_valid), .mem_valid(l1_mem_valid), .out_valid(l1_out_valid),
    .rdata(l1_rdata), .ram_en(l1_ram_en), .ram_we(l1_ram_we), .ram_addr(l1_ram_addr),
    .ram_wdata(l1_ram_wdata), .ram_rdata(16'h5A5A), .busy(l1_busy)
  );

  mem_port_arbiter #(.RAM_LAT(3)) dut_l3 (
    .clk(clk), .rst_n(rst_aux_n),
    .if_req(1'b1), .if_addr(3'd2),
    .mem_req(1'b0), .mem_we(1'b0), .mem_addr(3'd0), .mem_wdata(16'd0),
    .out_req(1'b0), .out_addr(3'd0),
    .if_gnt(l3_if_gnt), .mem_gnt(l3_mem_gnt), .out_gnt(l3_out_gnt),
    .if_valid(l3_if_valid), .mem_valid(l3_mem_valid), .out_valid(l3_out_valid),
    .rdata(l3_rdata), .ram_en(l3_ram_en), .ram_we(l3_ram_we), .ram_addr(l3_ram_addr),
    .ram_wdata(l3_ram_wdata), .ram_rdata(16'hC3C3), .busy(l3_busy)
  );

  // RAM model: read data is only meaningful after the ram_en cycle of a read.
  logic [15:0] ram [8] = '{16'h0A00, 16'h0A11, 16'h0A22, 16'h0A33,
                           16'h0A44, 16'h1234, 16'h0A66, 16'h0A77};
  logic [2:0]  rd_addr_l = 3'd0;
  logic        rd_inflight = 1'b0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      rd_addr_l   <= ram_addr;
      rd_inflight <= !ram_we;
    end else if (mem_valid | if_valid | out_valid) begin
      rd_inflight <= 1'b0;
    end
  end
  assign ram_rdata = rd_inflight ? ram[rd_addr_l] : 16'hDEAD;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic [1:0] id, input logic [15:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest expectation.
  int multi_err = 0;
  always @(negedge clk) begin
    logic [2:0] vv;
    logic [2:0] ev;
    exp_t e;
    vv = {out_valid, if_valid, mem_valid};
    if ($countones({out_gnt, if_gnt, mem_gnt}) > 1 || $countones(vv) > 1) multi_err++;
    if (vv != 3'b000) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(vv), 32'd0);
      end else begin
        e  = sb.pop_front();
        ev = 3'b001 << e.id;
        check("valid_id", 32'(vv), 32'(ev));
        check("valid_rdata", 32'(rdata), 32'(e.data));
        check("gnt_in_resp", 32'({out_gnt, if_gnt, mem_gnt}), 32'(ev));
      end
    end
  end

  task automatic wait_valid(input string tag, input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_valid | if_valid | out_valid) && n < max);
    if (!(mem_valid | if_valid | out_valid)) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t_prev;
    int t1[$];
    int t3[$];
    logic [1:0] exp_ids[6];
    rst_n = 1'b0; rst_aux_n = 1'b0;
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; out_req = 1'b0;
    if_addr = 3'd0; mem_addr = 3'd0; out_addr = 3'd0; mem_wdata = 16'd0;
    repeat (2) @(negedge clk);

    check("rst_gnt", 32'({out_gnt, if_gnt, mem_gnt}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Single fetch read, latency 2.
    if_req = 1'b1; if_addr = 3'd5;
    push(ID_IF, 16'h1234);
    @(negedge clk);
    check("t1_gnt", 32'({out_gnt, if_gnt, mem_gnt}), 32'b010);
    check("t1_ram_en", 32'(ram_en), 32'd1);
    check("t1_ram_addr", 32'(ram_addr), 32'd5);
    check("t1_ram_we", 32'(ram_we), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_ram_en_once", 32'(ram_en), 32'd0);
    check("t1_gnt_held", 32'(if_gnt), 32'd1);
    check("t1_no_early_valid", 32'(if_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_cycle3", 32'(if_valid), 32'd1);
    if_req = 1'b0;
    @(negedge clk);
    check("t1_back_idle", 32'({busy, out_gnt, if_gnt, mem_gnt}), 32'd0);

    // Data-stage write leaves rdata untouched, then read it back through out.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 3'd3; mem_wdata = 16'hBEEF;
    push(ID_MEM, 16'h1234);
    @(negedge clk);
    check("t2_gnt", 32'({out_gnt, if_gnt, mem_gnt}), 32'b001);
    check("t2_ram_en", 32'(ram_en), 32'd1);
    check("t2_ram_we", 32'(ram_we), 32'd1);
    check("t2_ram_addr", 32'(ram_addr), 32'd3);
    check("t2_ram_wdata", 32'(ram_wdata), 32'hBEEF);
    wait_valid("t2", 8);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    out_req = 1'b1; out_addr = 3'd3;
    push(ID_OUT, 16'hBEEF);
    wait_valid("t2_readback", 8);
    out_req = 1'b0;
    @(negedge clk);

    // All three at once, each drops after its own valid.
    mem_addr = 3'd1; if_addr = 3'd2; out_addr = 3'd4;
    mem_req = 1'b1; if_req = 1'b1; out_req = 1'b1;
    push(ID_MEM, 16'h0A11); push(ID_IF, 16'h0A22); push(ID_OUT, 16'h0A44);
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_valid("t3", 10);
      if (i > 0) check("t3_valid_gap", 32'(cyc - t_prev), 32'd4);
      t_prev = cyc;
      if (mem_valid) mem_req = 1'b0;
      if (if_valid)  if_req  = 1'b0;
      if (out_valid) out_req = 1'b0;
    end
    mem_req = 1'b0; if_req = 1'b0; out_req = 1'b0;
    @(negedge clk);

    // Requests held continuously: rotation only with the round-robin option.
`ifdef ARB_ROUND_ROBIN_EN
    exp_ids = '{ID_MEM, ID_IF, ID_OUT, ID_MEM, ID_IF, ID_OUT};
`else
    exp_ids = '{ID_MEM, ID_MEM, ID_MEM, ID_MEM, ID_MEM, ID_MEM};
`endif
    for (int i = 0; i < 6; i++) begin
      case (exp_ids[i])
        ID_MEM:  push(ID_MEM, 16'h0A11);
        ID_IF:   push(ID_IF, 16'h0A22);
        default: push(ID_OUT, 16'h0A44);
      endcase
    end
    mem_req = 1'b1; if_req = 1'b1; out_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_valid("t4", 10);
      if (i > 0) check("t4_valid_gap", 32'(cyc - t_prev), 32'd4);
      t_prev = cyc;
    end
    mem_req = 1'b0; if_req = 1'b0; out_req = 1'b0;
    @(negedge clk);

    // Reset in the second WAIT cycle kills the access; the held request is regranted.
    if_req = 1'b1; if_addr = 3'd6;
    @(negedge clk);
    check("t5_gnt", 32'({out_gnt, if_gnt, mem_gnt}), 32'b010);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_gnt", 32'({out_gnt, if_gnt, mem_gnt}), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_ram_en", 32'(ram_en), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push(ID_IF, 16'h0A66);
    @(negedge clk);
    check("t5_regrant", 32'({out_gnt, if_gnt, mem_gnt}), 32'b010);
    wait_valid("t5", 8);
    if_req = 1'b0;
    @(negedge clk);

    // Back-to-back fetches on the latency-1 and latency-3 instances.
    rst_aux_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (l1_if_valid) begin
        t1.push_back(cyc);
        if (t1.size() == 1) check("lat1_rdata", 32'(l1_rdata), 32'h5A5A);
      end
      if (l3_if_valid) begin
        t3.push_back(cyc);
        if (t3.size() == 1) check("lat3_rdata", 32'(l3_rdata), 32'hC3C3);
      end
    end
    if (t1.size() >= 2) check("lat1_valid_gap", 32'(t1[1] - t1[0]), 32'd3);
    else                check("lat1_valid_count", 32'(t1.size()), 32'd2);
    if (t3.size() >= 2) check("lat3_valid_gap", 32'(t3[1] - t3[0]), 32'd5);
    else                check("lat3_valid_count", 32'(t3.size()), 32'd2);

    check("gnt_valid_onehot", 32'(multi_err), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
